// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side bus of the async_fifo write-port arbiter: requests, data, FIFO full flag in;
// grant, write strobe, muxed data and current owner out.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) ();
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  wfull;
  logic [NREQ-1:0]       gnt;
  logic                  write;
  logic [WIDTH-1:0]      wdata;
  logic [IDW-1:0]        owner;

  // master is the requester/FIFO side, which also supplies wfull
  modport master (output req, req_data, wfull, input gnt, write, wdata, owner);
  modport slave  (input req, req_data, wfull, output gnt, write, wdata, owner);
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the async_fifo write port, one beat per cycle, stalls on wfull.
// Define FIFO_ARB_BURST_LOCK_EN to let a grantee keep ownership for up to MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset_b,
  fifo_wr_arbiter_if.slave  bus
);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("fifo_wr_arbiter: NREQ must be 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
    $error("fifo_wr_arbiter: MAX_BURST must be 1..15");
  end

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] p);
    if (int'(p) >= NREQ - 1) return '0;
    return p + 1'b1;
  endfunction

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  // MSB = found; scanning downward lets the lowest offset from start win
  function automatic logic [IDW:0] pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] start);
    logic [IDW-1:0] idx;
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = wrap_add(start, k);
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  logic [IDW-1:0] rr_ptr, rr_n;
  logic [IDW-1:0] owner, owner_n;
  logic [IDW-1:0] start, g;
  logic [IDW:0]   pk;
  logic           go;
  logic [NREQ-1:0]  gnt_c;
  logic [WIDTH-1:0] wdata_c;

`ifdef FIFO_ARB_BURST_LOCK_EN
  typedef enum logic {IDLE, BURST} state_t;
  localparam logic [3:0] BURST_LEN = 4'(MAX_BURST);
  state_t         state, state_n;
  logic [IDW-1:0] own, own_n;
  logic [3:0]     cnt, cnt_n;
  logic           keep;
`endif

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      rr_ptr <= '0;
      owner  <= '0;
`ifdef FIFO_ARB_BURST_LOCK_EN
      state  <= IDLE;
      own    <= '0;
      cnt    <= '0;
`endif
    end else begin
      rr_ptr <= rr_n;
      owner  <= owner_n;
`ifdef FIFO_ARB_BURST_LOCK_EN
      state  <= state_n;
      own    <= own_n;
      cnt    <= cnt_n;
`endif
    end
  end

  always_comb begin
    go      = 1'b0;
    g       = '0;
    rr_n    = rr_ptr;
    owner_n = owner;
    start   = rr_ptr;
`ifdef FIFO_ARB_BURST_LOCK_EN
    state_n = state;
    own_n   = own;
    cnt_n   = cnt;
    keep    = (state == BURST) && bus.req[own];
    // a released owner hands the scan to its neighbour in the same cycle
    if (state == BURST) start = wrap_inc(own);
`endif
    pk = pick(bus.req, start);

    if (reset_b && !bus.wfull) begin
`ifdef FIFO_ARB_BURST_LOCK_EN
      if (keep) begin
        go    = 1'b1;
        g     = own;
        cnt_n = cnt + 4'd1;
        if (cnt + 4'd1 == BURST_LEN) begin
          state_n = IDLE;
          rr_n    = wrap_inc(own);
        end
      end else begin
        if (state == BURST) begin
          state_n = IDLE;
          rr_n    = wrap_inc(own);
        end
        if (pk[IDW]) begin
          go = 1'b1;
          g  = pk[IDW-1:0];
          if (MAX_BURST > 1) begin
            state_n = BURST;
            own_n   = pk[IDW-1:0];
            cnt_n   = 4'd1;
          end else begin
            rr_n = wrap_inc(pk[IDW-1:0]);
          end
        end
      end
`else
      if (pk[IDW]) begin
        go   = 1'b1;
        g    = pk[IDW-1:0];
        rr_n = wrap_inc(pk[IDW-1:0]);
      end
`endif
      if (go) owner_n = g;
    end
  end

  always_comb begin
    gnt_c   = '0;
    wdata_c = '0;
    if (go) begin
      gnt_c[g] = 1'b1;
      wdata_c  = bus.req_data[int'(g)*WIDTH +: WIDTH];
    end
  end

  assign bus.gnt   = gnt_c;
  assign bus.write = |(bus.req & gnt_c);
  assign bus.wdata = wdata_c;
  assign bus.owner = owner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scoreboard bench: a 4-requester arbiter and a 3-requester arbiter (MAX_BURST=1).
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic reset_b;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(4), .WIDTH(8)) b4 ();
  fifo_wr_arbiter_if #(.NREQ(3), .WIDTH(8)) b3 ();

  fifo_wr_arbiter #(.NREQ(4), .WIDTH(8), .MAX_BURST(4)) u4 (
    .clk(clk), .reset_b(reset_b), .bus(b4.slave));
  fifo_wr_arbiter #(.NREQ(3), .WIDTH(8), .MAX_BURST(1)) u3 (
    .clk(clk), .reset_b(reset_b), .bus(b3.slave));

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] data;
    logic [1:0] owner;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] dat(input logic [3:0] g, input logic [7:0] base);
    for (int i = 0; i < 4; i++)
      if (g[i]) return base + 8'(i);
    return 8'h00;
  endfunction

  task automatic step4(input logic rb, input logic [3:0] r, input logic wf,
                       input logic [3:0] g, input logic [1:0] o);
    @(posedge clk); #1;
    reset_b = rb; b4.req = r; b4.wfull = wf; b3.req = '0; b3.wfull = 1'b0;
    q4.push_back('{gnt: g, data: dat(g, 8'hA0), owner: o});
  endtask

  task automatic step3(input logic [2:0] r, input logic [2:0] g, input logic [1:0] o);
    @(posedge clk); #1;
    reset_b = 1'b1; b3.req = r; b3.wfull = 1'b0; b4.req = '0; b4.wfull = 1'b0;
    q3.push_back('{gnt: {1'b0, g}, data: dat({1'b0, g}, 8'h50), owner: o});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      checks++;
      if (b4.gnt !== e.gnt || b4.write !== (e.gnt != 4'b0) || b4.wdata !== e.data ||
          b4.owner !== e.owner) begin
        errors++;
        $display("FAIL arb4 t=%0t gnt=%b write=%b wdata=%h owner=%0d, required gnt=%b wdata=%h owner=%0d",
                 $time, b4.gnt, b4.write, b4.wdata, b4.owner, e.gnt, e.data, e.owner);
      end
    end else if (b4.write !== 1'b0) begin
      checks++; errors++;
      $display("FAIL arb4_unexpected_write t=%0t write=%b, required 0", $time, b4.write);
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      checks++;
      if (b3.gnt !== e.gnt[2:0] || b3.write !== (e.gnt != 4'b0) || b3.wdata !== e.data ||
          b3.owner !== e.owner) begin
        errors++;
        $display("FAIL arb3 t=%0t gnt=%b write=%b wdata=%h owner=%0d, required gnt=%b wdata=%h owner=%0d",
                 $time, b3.gnt, b3.write, b3.wdata, b3.owner, e.gnt[2:0], e.data, e.owner);
      end
    end else if (b3.write !== 1'b0) begin
      checks++; errors++;
      $display("FAIL arb3_unexpected_write t=%0t write=%b, required 0", $time, b3.write);
    end
  end

  initial begin
    reset_b = 1'b0;
    b4.req = 4'b1111; b4.wfull = 1'b0; b4.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    b3.req = 3'b000;  b3.wfull = 1'b0; b3.req_data = {8'h52, 8'h51, 8'h50};

    for (int i = 0; i < 3; i++) step4(1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0);
    step4(1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0);
`ifndef FIFO_ARB_BURST_LOCK_EN
    step4(1'b1, 4'b1111, 1'b0, 4'b0010, 2'd0);
    step4(1'b1, 4'b1111, 1'b0, 4'b0100, 2'd1);
    step4(1'b1, 4'b1111, 1'b0, 4'b1000, 2'd2);
    step4(1'b1, 4'b1111, 1'b0, 4'b0001, 2'd3);
    step4(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0);
    step4(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0);
    step4(1'b1, 4'b1111, 1'b0, 4'b0010, 2'd0);
    step4(1'b1, 4'b0101, 1'b0, 4'b0100, 2'd1);
    step4(1'b1, 4'b0101, 1'b0, 4'b0001, 2'd2);
    step4(1'b1, 4'b1010, 1'b0, 4'b0010, 2'd0);
    step4(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd1);
`else
    for (int i = 0; i < 3; i++) step4(1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0);
    step4(1'b1, 4'b0011, 1'b0, 4'b0010, 2'd0);
    for (int i = 0; i < 3; i++) step4(1'b1, 4'b0011, 1'b0, 4'b0010, 2'd1);
    step4(1'b1, 4'b0011, 1'b0, 4'b0001, 2'd1);
    step4(1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0);
    // owner 0 drops mid-burst: req2 must be granted in the same cycle
    step4(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd0);
    step4(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd2);
    step4(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd2);
    for (int i = 0; i < 5; i++) step4(1'b1, 4'b0010, 1'b1, 4'b0000, 2'd1);
    for (int i = 0; i < 3; i++) step4(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1);
    step4(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd1);
`endif

    step3(3'b100, 3'b100, 2'd0);
    step3(3'b111, 3'b001, 2'd2);
    step3(3'b111, 3'b010, 2'd0);
    step3(3'b111, 3'b100, 2'd1);
    step3(3'b111, 3'b001, 2'd2);
    step3(3'b000, 3'b000, 2'd0);

    step4(1'b1, 4'b1111, 1'b0, 4'b0100, 2'd1);
    step4(1'b0, 4'b1111, 1'b0, 4'b0000, 2'd2);
    step4(1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0);
    step4(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0);

    for (int i = 0; i < 20 && (q4.size() > 0 || q3.size() > 0); i++) @(negedge clk);
    @(posedge clk); #1;
    if (q4.size() > 0 || q3.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d, required 0", q4.size() + q3.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
